// File: rtl/mat_mult_pkg.sv
// Shared types and helpers for the time-multiplexed complex matrix multiplier.
package mat_mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } mm_state_t;

    // Full-precision output component width: a sum of N products of two
    // W-bit signed complex values, each product needing 2W+1 bits.
    function automatic int mm_out_w(input int w, input int n);
        return 2 * w + $clog2(n) + 1;
    endfunction

    // Flat index of element (i,j) in an n x n matrix.
    function automatic int elem_idx(input int i, input int j, input int n);
        return i * n + j;
    endfunction

    // LSB of the real component of element idx on a flat bus of width-w components.
    function automatic int re_lo(input int idx, input int w);
        return w * idx;
    endfunction

    // LSB of the imaginary component; imaginary parts follow all real parts.
    function automatic int im_lo(input int idx, input int w, input int nn);
        return w * nn + w * idx;
    endfunction

endpackage

// File: rtl/mat_mult_complex_tm_cmac_lane.sv
// One complex multiply-accumulate lane with loadable accumulator.
// acc_re/acc_im present the running sum including the current term, so the
// final sum of a dot product is available in the same cycle as its last term.
module cmac_lane #(
    parameter int W  = 16,
    parameter int OW = 34
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic signed [OW-1:0] init_re,
    input  logic signed [OW-1:0] init_im,
    input  logic                 en,
    input  logic                 conj_b,
    input  logic signed [W-1:0]  a_re,
    input  logic signed [W-1:0]  a_im,
    input  logic signed [W-1:0]  b_re,
    input  logic signed [W-1:0]  b_im,
    output logic signed [OW-1:0] acc_re,
    output logic signed [OW-1:0] acc_im
);

    logic signed [OW-1:0] r_acc_re, r_acc_im;
    logic signed [OW-1:0] w_ar, w_ai, w_br, w_bi;
    logic signed [OW-1:0] w_rr, w_ii, w_ri, w_ir;
    logic signed [OW-1:0] w_p_re, w_p_im;

    // Sign-extend operands so every product and sum is formed at OW bits.
    assign w_ar = OW'(a_re);
    assign w_ai = OW'(a_im);
    assign w_br = OW'(b_re);
    assign w_bi = OW'(b_im);

    assign w_rr = w_ar * w_br;
    assign w_ii = w_ai * w_bi;
    assign w_ri = w_ar * w_bi;
    assign w_ir = w_ai * w_br;

    // Conjugating B flips the sign of bi, which swaps the sign of the cross terms.
    assign w_p_re = conj_b ? (w_rr + w_ii) : (w_rr - w_ii);
    assign w_p_im = conj_b ? (w_ir - w_ri) : (w_ri + w_ir);

    assign acc_re = r_acc_re + w_p_re;
    assign acc_im = r_acc_im + w_p_im;

    // Accumulator: load takes priority so a new dot product starts cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_re <= '0;
            r_acc_im <= '0;
        end else if (load) begin
            r_acc_re <= init_re;
            r_acc_im <= init_im;
        end else if (en) begin
            r_acc_re <= acc_re;
            r_acc_im <= acc_im;
        end
    end

endmodule

// File: rtl/mat_mult_complex_tm.sv
// Time-multiplexed complex N x N matrix multiplier: LANES output elements are
// computed per group, one term k per cycle, groups processed in order.
module mat_mult_complex_tm
    import mat_mult_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 16,
    parameter int LANES = 4,
    localparam int OW   = mm_out_w(W, N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    acc_en,
    input  logic                    conj_b,
    input  logic [2*W*N*N-1:0]      mat_a,
    input  logic [2*W*N*N-1:0]      mat_b,
    output logic                    in_ready,
    output logic [2*OW*N*N-1:0]     mat_out,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int NN = N * N;
    localparam int G  = NN / LANES;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int KW = $clog2(N);

    if ((NN % LANES) != 0) begin : g_bad_lanes
        $error("LANES must divide N*N");
    end

    mm_state_t            r_state, w_state_next;
    logic [KW-1:0]        r_k;
    logic [GW-1:0]        r_g;
    logic [GW-1:0]        w_g_init;
    logic [2*W*NN-1:0]    r_mat_a, r_mat_b;
    logic                 r_acc_en, r_conj_b;
    logic [2*OW*NN-1:0]   r_mat_out;
    logic                 w_accept, w_last_k, w_last_g, w_load, w_en, w_init_acc;

    logic signed [OW-1:0] w_sum_re [LANES];
    logic signed [OW-1:0] w_sum_im [LANES];

    assign w_accept   = start && (r_state == IDLE);
    assign w_last_k   = (r_k == KW'(N - 1));
    assign w_last_g   = (r_g == GW'(G - 1));
    assign w_en       = (r_state == COMPUTE);
    assign w_load     = w_accept || (w_en && w_last_k && !w_last_g);
    // At accept the job flags are not registered yet, so use the live input.
    assign w_init_acc = (r_state == IDLE) ? acc_en : r_acc_en;
    assign w_g_init   = (w_en && !w_last_g) ? r_g + 1'b1 : '0;
    assign mat_out    = r_mat_out;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' with a default first, so
        // every path assigns every output and no latch is inferred.
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (start) w_state_next = COMPUTE;
            end
            COMPUTE: begin
                if (w_last_k && w_last_g) w_state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Term counter k and group counter g.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k <= '0;
            r_g <= '0;
        end else if (w_accept) begin
            r_k <= '0;
            r_g <= '0;
        end else if (w_en) begin
            if (w_last_k) begin
                r_k <= '0;
                if (!w_last_g) r_g <= r_g + 1'b1;
            end else begin
                r_k <= r_k + 1'b1;
            end
        end
    end

    // Job operand capture at accept.
    // NOTE: operand registers carry no reset; they are only read during a job
    // that has just loaded them, so a reset network here buys nothing.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mat_a  <= mat_a;
            r_mat_b  <= mat_b;
            r_acc_en <= acc_en;
            r_conj_b <= conj_b;
        end
    end

    // Result write-back: each lane stores its finished element after term N-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mat_out <= '0;
        end else if (w_en && w_last_k) begin
            for (int l = 0; l < LANES; l++) begin
                r_mat_out[re_lo(int'(r_g) * LANES + l, OW) +: OW]     <= w_sum_re[l];
                r_mat_out[im_lo(int'(r_g) * LANES + l, OW, NN) +: OW] <= w_sum_im[l];
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        int                   w_e, w_i, w_j, w_e_init, w_a_idx, w_b_idx;
        logic signed [W-1:0]  w_a_re, w_a_im, w_b_re, w_b_im;
        logic signed [OW-1:0] w_init_re, w_init_im;

        assign w_e      = int'(r_g) * LANES + l;
        assign w_i      = w_e / N;
        assign w_j      = w_e % N;
        assign w_a_idx  = elem_idx(w_i, int'(r_k), N);
        assign w_b_idx  = elem_idx(int'(r_k), w_j, N);
        assign w_e_init = int'(w_g_init) * LANES + l;

        assign w_a_re = r_mat_a[re_lo(w_a_idx, W) +: W];
        assign w_a_im = r_mat_a[im_lo(w_a_idx, W, NN) +: W];
        assign w_b_re = r_mat_b[re_lo(w_b_idx, W) +: W];
        assign w_b_im = r_mat_b[im_lo(w_b_idx, W, NN) +: W];

        // Accumulate mode seeds the lane with the previous result element.
        assign w_init_re = w_init_acc ? r_mat_out[re_lo(w_e_init, OW) +: OW]     : '0;
        assign w_init_im = w_init_acc ? r_mat_out[im_lo(w_e_init, OW, NN) +: OW] : '0;

        cmac_lane #(
            .W  (W),
            .OW (OW)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (w_load),
            .init_re (w_init_re),
            .init_im (w_init_im),
            .en      (w_en),
            .conj_b  (r_conj_b),
            .a_re    (w_a_re),
            .a_im    (w_a_im),
            .b_re    (w_b_re),
            .b_im    (w_b_im),
            .acc_re  (w_sum_re[l]),
            .acc_im  (w_sum_im[l])
        );
    end

endmodule

// File: tb/tb_mat_mult_complex_tm.sv
// Directed bench: a 2x2/2-lane instance for functional cases and a default
// 4x4/4-lane instance for the reset-abort case.
module tb_mat_mult_complex_tm;

    localparam int W   = 16;
    localparam int N2  = 2;
    localparam int NN2 = 4;
    localparam int OW2 = 34;
    localparam int N4  = 4;
    localparam int NN4 = 16;
    localparam int OW4 = 35;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                   start2 = 0, acc2 = 0, conj2 = 0, ordy2 = 0;
    logic [2*W*NN2-1:0]     a2 = '0, b2 = '0;
    logic                   ir2, ov2;
    logic [2*OW2*NN2-1:0]   out2;

    logic                   start4 = 0, acc4 = 0, conj4 = 0, ordy4 = 0;
    logic [2*W*NN4-1:0]     a4 = '0, b4 = '0;
    logic                   ir4, ov4;
    logic [2*OW4*NN4-1:0]   out4;

    int checks = 0;
    int errors = 0;

    mat_mult_complex_tm #(.N(N2), .W(W), .LANES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .acc_en(acc2), .conj_b(conj2),
        .mat_a(a2), .mat_b(b2), .in_ready(ir2), .mat_out(out2),
        .out_valid(ov2), .out_ready(ordy2)
    );

    mat_mult_complex_tm dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .acc_en(acc4), .conj_b(conj4),
        .mat_a(a4), .mat_b(b4), .in_ready(ir4), .mat_out(out4),
        .out_valid(ov4), .out_ready(ordy4)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] o2re(input int e);
        return 64'($signed(out2[OW2*e +: OW2]));
    endfunction
    function automatic logic signed [63:0] o2im(input int e);
        return 64'($signed(out2[OW2*NN2 + OW2*e +: OW2]));
    endfunction
    function automatic logic signed [63:0] o4re(input int e);
        return 64'($signed(out4[OW4*e +: OW4]));
    endfunction
    function automatic logic signed [63:0] o4im(input int e);
        return 64'($signed(out4[OW4*NN4 + OW4*e +: OW4]));
    endfunction

    task automatic set2(input bit is_a, input int i, input int j, input int re, input int im);
        if (is_a) begin
            a2[W*(i*N2+j) +: W]         = 16'(re);
            a2[W*NN2 + W*(i*N2+j) +: W] = 16'(im);
        end else begin
            b2[W*(i*N2+j) +: W]         = 16'(re);
            b2[W*NN2 + W*(i*N2+j) +: W] = 16'(im);
        end
    endtask

    // A = B = diag(1j, 1j)
    task automatic set_diag_j2();
        a2 = '0;
        b2 = '0;
        set2(1, 0, 0, 0, 1);
        set2(1, 1, 1, 0, 1);
        set2(0, 0, 0, 0, 1);
        set2(0, 1, 1, 0, 1);
    endtask

    // Launch a job on the 2x2 instance and wait for out_valid; operands and
    // flags are scrambled right after accept to prove they were captured.
    task automatic job2(input logic acc, input logic conj, input string tag);
        int cyc;
        check({tag, "_rdy"}, ir2, 1);
        acc2   = acc;
        conj2  = conj;
        start2 = 1;
        @(posedge clk); #1;
        start2 = 0;
        acc2   = ~acc;
        conj2  = ~conj;
        a2     = {4{$urandom()}};
        b2     = {4{$urandom()}};
        check({tag, "_busy"}, ir2, 0);
        cyc = 0;
        while (!ov2 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, 4);
    endtask

    task automatic ack2(input string tag);
        ordy2 = 1;
        @(posedge clk); #1;
        ordy2 = 0;
        check({tag, "_ack_rdy"}, ir2, 1);
        check({tag, "_ack_valid"}, ov2, 0);
    endtask

    task automatic check_diag2(input string tag, input int dre, input int dim);
        for (int e = 0; e < NN2; e++) begin
            check($sformatf("%s_re%0d", tag, e), o2re(e), (e / N2 == e % N2) ? dre : 0);
            check($sformatf("%s_im%0d", tag, e), o2im(e), (e / N2 == e % N2) ? dim : 0);
        end
    endtask

    initial begin
        logic [2*OW2*NN2-1:0] saved;
        int cyc;
        int ar, ai;

        // ---------------- reset state ----------------
        #12;
        check("rst_rdy2", ir2, 1);
        check("rst_valid2", ov2, 0);
        check("rst_out2_zero", |out2, 0);
        check("rst_rdy4", ir4, 1);
        check("rst_valid4", ov4, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // ---------------- identity ----------------
        a2 = '0;
        b2 = '0;
        set2(1, 0, 0, 1, 2);
        set2(1, 0, 1, 3, 0);
        set2(1, 1, 0, 0, 0);
        set2(1, 1, 1, 0, -1);
        set2(0, 0, 0, 1, 0);
        set2(0, 1, 1, 1, 0);
        job2(0, 0, "ident");
        check("ident_re0", o2re(0), 1);
        check("ident_im0", o2im(0), 2);
        check("ident_re1", o2re(1), 3);
        check("ident_im1", o2im(1), 0);
        check("ident_re2", o2re(2), 0);
        check("ident_im2", o2im(2), 0);
        check("ident_re3", o2re(3), 0);
        check("ident_im3", o2im(3), -1);
        ack2("ident");

        // ---------------- conjugate ----------------
        set_diag_j2();
        job2(0, 0, "jj");
        check_diag2("jj", -1, 0);
        ack2("jj");
        set_diag_j2();
        job2(0, 1, "jconj");
        check_diag2("jconj", 1, 0);
        ack2("jconj");

        // ---------------- accumulate ----------------
        set_diag_j2();
        job2(0, 0, "acc_first");
        check_diag2("acc_first", -1, 0);
        ack2("acc_first");
        set_diag_j2();
        job2(1, 0, "acc_add");
        check_diag2("acc_add", -2, 0);
        ack2("acc_add");
        set_diag_j2();
        job2(0, 0, "acc_off");
        check_diag2("acc_off", -1, 0);
        ack2("acc_off");

        // ---------------- extremes ----------------
        a2 = {(2*NN2){16'h8000}};
        b2 = {(2*NN2){16'h8000}};
        job2(0, 0, "ext");
        for (int e = 0; e < NN2; e++) begin
            check($sformatf("ext_re%0d", e), o2re(e), 0);
            check($sformatf("ext_im%0d", e), o2im(e), 64'sd4294967296);
        end

        // ---------------- backpressure (extremes result held) ----------------
        saved = out2;
        for (int c = 0; c < 10; c++) begin
            start2 = 1;
            a2     = {4{$urandom()}};
            @(posedge clk); #1;
            check($sformatf("bp_valid_c%0d", c), ov2, 1);
            check($sformatf("bp_rdy_c%0d", c), ir2, 0);
            check($sformatf("bp_hold_c%0d", c), out2 === saved, 1);
        end
        start2 = 0;
        ack2("bp");
        check("bp_out_after_ack", out2 === saved, 1);
        @(posedge clk); #1;
        check("bp_idle_stays", ir2, 1);

        // ---------------- reset mid-COMPUTE (default params) ----------------
        a4     = {16{$urandom()}};
        b4     = {16{$urandom()}};
        acc4   = 0;
        start4 = 1;
        @(posedge clk); #1;
        start4 = 0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_busy", ir4, 0);
        rst_n = 0;
        #1;
        check("abort_rdy", ir4, 1);
        check("abort_valid", ov4, 0);
        check("abort_out_zero", |out4, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        // Fresh job with acc_en=1: a clean reset leaves C=0, so result = A*B.
        // A[i][j] = (4i+j+1) - (i+j)j, B = diag(2+1j).
        a4 = '0;
        b4 = '0;
        for (int i = 0; i < N4; i++) begin
            for (int j = 0; j < N4; j++) begin
                a4[W*(i*N4+j) +: W]         = 16'(i*4 + j + 1);
                a4[W*NN4 + W*(i*N4+j) +: W] = 16'(-(i + j));
            end
            b4[W*(i*N4+i) +: W]         = 16'(2);
            b4[W*NN4 + W*(i*N4+i) +: W] = 16'(1);
        end
        check("fresh_rdy", ir4, 1);
        acc4   = 1;
        start4 = 1;
        @(posedge clk); #1;
        start4 = 0;
        acc4   = 0;
        cyc    = 0;
        while (!ov4 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("fresh_latency", cyc, 16);
        for (int e = 0; e < NN4; e++) begin
            ar = e + 1;
            ai = -((e / N4) + (e % N4));
            check($sformatf("fresh_re%0d", e), o4re(e), 2*ar - ai);
            check($sformatf("fresh_im%0d", e), o4im(e), ar + 2*ai);
        end
        ordy4 = 1;
        @(posedge clk); #1;
        ordy4 = 0;
        check("fresh_ack_rdy", ir4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
